// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   DATA_W      : datapath / instruction width
//   OPC_HALT    : opcode value that stops fetching
//   NOP_INST    : instruction word used for bubbles
//   fetch_state_e : fetch FSM states
//   opcode()    : extracts the opcode field [15:12] of an instruction word
package fetch_stage_pkg;

  localparam int DATA_W = 16;
  localparam logic [3:0] OPC_HALT = 4'hF;
  localparam logic [DATA_W-1:0] NOP_INST = 16'h0000;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode(input logic [DATA_W-1:0] word);
    return word[15:12];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage and its neighbours
// (hazard unit, EXE redirect, decode via the IF/ID register).
//   stall_if, branch_taken, branch_target : into fetch
//   pc, next_pc                           : fetch PC and pc+1 (combinational)
//   inst, next_pc_id, valid_id            : IF/ID register
//   halted                                : fetch FSM is in HALT
//   perf_fetch_cnt, perf_flush_cnt        : present only with FETCH_PERF_EN
// Modports: master = fetch stage, slave = the surrounding pipeline.
interface fetch_stage_if;

  logic                                 stall_if;
  logic                                 branch_taken;
  logic [fetch_stage_pkg::DATA_W-1:0]   branch_target;
  logic [fetch_stage_pkg::DATA_W-1:0]   pc;
  logic [fetch_stage_pkg::DATA_W-1:0]   next_pc;
  logic [fetch_stage_pkg::DATA_W-1:0]   inst;
  logic [fetch_stage_pkg::DATA_W-1:0]   next_pc_id;
  logic                                 valid_id;
  logic                                 halted;
`ifdef FETCH_PERF_EN
  logic [fetch_stage_pkg::DATA_W-1:0]   perf_fetch_cnt;
  logic [fetch_stage_pkg::DATA_W-1:0]   perf_flush_cnt;
`endif

  modport master (
    input  stall_if, branch_taken, branch_target,
    output pc, next_pc, inst, next_pc_id, valid_id, halted
`ifdef FETCH_PERF_EN
    , output perf_fetch_cnt, perf_flush_cnt
`endif
  );

  modport slave (
    output stall_if, branch_taken, branch_target,
    input  pc, next_pc, inst, next_pc_id, valid_id, halted
`ifdef FETCH_PERF_EN
    , input perf_fetch_cnt, perf_flush_cnt
`endif
  );

endinterface

// File: rtl/fetch_stage_imem_rom.sv
// Word-addressed instruction ROM with asynchronous read.
//   DEPTH     : number of 16-bit words (power of 2)
//   INIT_FILE : image name kept for interface compatibility
//   addr      : word address (log2(DEPTH) bits)
//   data      : instruction word at addr, combinational
module imem_rom
   import fetch_stage_pkg::*;
#(
   parameter int    DEPTH     = 256,
   parameter string INIT_FILE = "imem.hex"
) (
   input  logic [$clog2(DEPTH)-1:0] addr,
   output logic [DATA_W-1:0]        data
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign data = mem[addr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 16-bit 5-stage pipeline.
// Holds the PC, reads the instruction ROM combinationally and loads the IF/ID register.
// Ports:
//   clk   : clock, all state changes on posedge
//   rst   : synchronous active-high reset
//   bus   : fetch_stage_if.master (stall/redirect in, PC and IF/ID out)
// Optional feature macro: FETCH_PERF_EN adds perf_fetch_cnt / perf_flush_cnt.
//
// state  | meaning
// S_RUN  | fetching; pc advances unless stalled
// S_HALT | HALT opcode fetched; pc frozen, IF/ID fed bubbles until a redirect or reset
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                IMEM_DEPTH = 256,
  parameter logic [DATA_W-1:0] RESET_PC   = 16'h0000,
  parameter string             INIT_FILE  = "imem.hex"
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  localparam int AW = $clog2(IMEM_DEPTH);

  fetch_state_e      state_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_inc;
  logic [DATA_W-1:0] fetch_word;
  logic [DATA_W-1:0] inst_q;
  logic [DATA_W-1:0] next_pc_id_q;
  logic              valid_q;
  logic              halted_q;
  logic              load_valid;

  // Upper PC bits are dropped here, so fetch addresses alias modulo IMEM_DEPTH.
  imem_rom #(
    .DEPTH     (IMEM_DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .addr (pc_q[AW-1:0]),
    .data (fetch_word)
  );

  assign pc_inc = pc_q + 16'd1;

  // A real instruction enters IF/ID only on an unstalled, unredirected RUN edge.
  assign load_valid = !rst && !bus.branch_taken && (state_q == S_RUN) && !bus.stall_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      next_pc_id_q <= '0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else if (bus.branch_taken) begin
      // Redirect wins over stall and HALT; the wrong-path fetch becomes a bubble.
      state_q  <= S_RUN;
      pc_q     <= bus.branch_target;
      inst_q   <= NOP_INST;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!bus.stall_if) begin
            inst_q       <= fetch_word;
            next_pc_id_q <= pc_inc;
            valid_q      <= 1'b1;
            if (opcode(fetch_word) == OPC_HALT) begin
              // HALT itself goes down the pipe, but the PC stays on it.
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_inc;
            end
          end
        end
        S_HALT: begin
          inst_q  <= NOP_INST;
          valid_q <= 1'b0;
        end
        default: begin
          state_q  <= S_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [DATA_W-1:0] perf_fetch_q;
  logic [DATA_W-1:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (load_valid)       perf_fetch_q <= perf_fetch_q + 16'd1;
      if (bus.branch_taken) perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign bus.perf_fetch_cnt = perf_fetch_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`else
  // Without perf counters load_valid has no consumer.
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
`endif

  assign bus.pc         = pc_q;
  assign bus.next_pc    = pc_inc;
  assign bus.inst       = inst_q;
  assign bus.next_pc_id = next_pc_id_q;
  assign bus.valid_id   = valid_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stall/branch/reset
// traffic, all compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus_if ();

  fetch_stage #(
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (16'h0000),
    .INIT_FILE  ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [15:0] rom_img [DEPTH];

  // model of the architectural state
  logic [15:0] m_pc, m_inst, m_npid, m_fcnt, m_flcnt;
  logic        m_valid, m_halt;
  bit          m_known = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: drive inputs, let the edge happen, advance the model, return at negedge.
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
    logic [15:0] w;
    rst                  = r;
    bus_if.stall_if      = s;
    bus_if.branch_taken  = b;
    bus_if.branch_target = t;
    @(posedge clk);
    if (r) begin
      m_pc = 16'h0000; m_inst = 16'h0000; m_npid = 16'h0000;
      m_valid = 1'b0; m_halt = 1'b0; m_fcnt = 16'h0; m_flcnt = 16'h0;
      m_known = 1'b1;
    end else if (b) begin
      m_pc = t; m_inst = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
      m_flcnt = m_flcnt + 16'd1;
    end else if (m_halt) begin
      m_inst = 16'h0000; m_valid = 1'b0;
    end else if (!s) begin
      w = rom_img[int'(m_pc) % DEPTH];
      m_inst = w; m_npid = m_pc + 16'd1; m_valid = 1'b1;
      m_fcnt = m_fcnt + 16'd1;
      if (w[15:12] == 4'hF) m_halt = 1'b1;
      else m_pc = m_pc + 16'd1;
    end
    @(negedge clk);
  endtask

  // continuous comparison against the model
  always @(negedge clk) begin
    if (m_known) begin
      chk("pc", bus_if.pc, m_pc);
      chk("next_pc", bus_if.next_pc, m_pc + 16'd1);
      chk("inst", bus_if.inst, m_inst);
      chk("valid_id", {15'd0, bus_if.valid_id}, {15'd0, m_valid});
      chk("halted", {15'd0, bus_if.halted}, {15'd0, m_halt});
      if (m_valid) chk("next_pc_id", bus_if.next_pc_id, m_npid);
`ifdef FETCH_PERF_EN
      chk("perf_fetch", bus_if.perf_fetch_cnt, m_fcnt);
      chk("perf_flush", bus_if.perf_flush_cnt, m_flcnt);
`endif
    end
  end

  initial begin
    rst = 1'b1;
    bus_if.stall_if = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.branch_target = 16'h0;

    for (int i = 0; i < DEPTH; i++) rom_img[i] = 16'($urandom);
    rom_img[0] = 16'h1234; rom_img[1] = 16'h2345; rom_img[2] = 16'h3456;
    rom_img[3] = 16'h4567; rom_img[4] = 16'h5678; rom_img[5] = 16'hF000;
    rom_img[6] = 16'h6001; rom_img[7] = 16'h7002; rom_img[8] = 16'h8003;
    rom_img[9] = 16'h9004; rom_img[10] = 16'h0A05;
    rom_img[8'h40] = 16'hABCD; rom_img[8'h41] = 16'h1111;
    rom_img[255] = 16'h0EEE;
    for (int i = 0; i < DEPTH; i++) dut.u_rom.mem[i] = rom_img[i];

    // reset state
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    chk("rst_pc", bus_if.pc, 16'h0000);
    chk("rst_valid", {15'd0, bus_if.valid_id}, 16'h0000);
    chk("rst_inst", bus_if.inst, 16'h0000);

    // 1: straight-line fetch
    step(0, 0, 0, 16'h0);
    chk("s1_inst0", bus_if.inst, 16'h1234);
    chk("s1_pc1", bus_if.pc, 16'h0001);
    step(0, 0, 0, 16'h0);
    chk("s1_inst1", bus_if.inst, 16'h2345);
    step(0, 0, 0, 16'h0);
    chk("s1_inst2", bus_if.inst, 16'h3456);
    chk("s1_pc3", bus_if.pc, 16'h0003);
    chk("s1_valid", {15'd0, bus_if.valid_id}, 16'h0001);
    chk("model_pin_pc", m_pc, 16'h0003);

    // 3: redirect together with stall
    step(0, 1, 1, 16'h0040);
    chk("s3_pc", bus_if.pc, 16'h0040);
    chk("s3_valid", {15'd0, bus_if.valid_id}, 16'h0000);
    chk("s3_inst_nop", bus_if.inst, 16'h0000);
    step(0, 0, 0, 16'h0);
    chk("s3_inst", bus_if.inst, 16'hABCD);
`ifdef FETCH_PERF_EN
    chk("s7_fetch_cnt", bus_if.perf_fetch_cnt, 16'd4);
    chk("s7_flush_cnt", bus_if.perf_flush_cnt, 16'd1);
`endif

    // 2: stall at pc=2 after a valid fetch
    step(0, 0, 1, 16'h0001);
    step(0, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    chk("s2_pc_hold", bus_if.pc, 16'h0002);
    chk("s2_inst_hold", bus_if.inst, 16'h2345);
    chk("s2_valid_hold", {15'd0, bus_if.valid_id}, 16'h0001);
    step(0, 0, 0, 16'h0);
    chk("s2_resume", bus_if.inst, 16'h3456);

    // 4: HALT at pc=5
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    chk("s4_halt_inst", bus_if.inst, 16'hF000);
    chk("s4_halted", {15'd0, bus_if.halted}, 16'h0001);
    chk("s4_pc", bus_if.pc, 16'h0005);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0);
    chk("s4_pc_idle", bus_if.pc, 16'h0005);
    chk("s4_valid_idle", {15'd0, bus_if.valid_id}, 16'h0000);
    step(0, 0, 1, 16'h0008);
    chk("s4_unhalt", {15'd0, bus_if.halted}, 16'h0000);
    chk("s4_pc8", bus_if.pc, 16'h0008);

    // 5: reset mid-stall and while halted
    step(0, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0);
    chk("s5_stall_rst_pc", bus_if.pc, 16'h0000);
    chk("s5_stall_rst_valid", {15'd0, bus_if.valid_id}, 16'h0000);
    step(0, 0, 1, 16'h0005);
    step(0, 0, 0, 16'h0);
    chk("s5_halted_pre", {15'd0, bus_if.halted}, 16'h0001);
    step(1, 0, 0, 16'h0);
    chk("s5_halt_rst_pc", bus_if.pc, 16'h0000);
    chk("s5_halt_rst_halted", {15'd0, bus_if.halted}, 16'h0000);

    // 6: aliasing and PC wrap
    step(0, 0, 1, 16'h0100);
    step(0, 0, 0, 16'h0);
    chk("s6_alias", bus_if.inst, 16'h1234);
    step(0, 0, 1, 16'hFFFF);
    chk("s6_next_pc_wrap", bus_if.next_pc, 16'h0000);
    step(0, 0, 0, 16'h0);
    chk("s6_wrap_inst", bus_if.inst, 16'h0EEE);
    chk("s6_wrap_pc", bus_if.pc, 16'h0000);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 25,
           $urandom_range(99) < 10, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
